// File: rtl/uart_pkg.sv
// Shared UART definitions: default clock period, baud periods, select codes
// and receiver states.
package uart_pkg;

    localparam int unsigned DEF_SYS_CLK_PERIOD = 20;

    localparam int unsigned BAUD_NS_9600   = 104167;
    localparam int unsigned BAUD_NS_19200  = 52083;
    localparam int unsigned BAUD_NS_38400  = 26041;
    localparam int unsigned BAUD_NS_57600  = 17361;
    localparam int unsigned BAUD_NS_115200 = 8680;

    typedef enum logic [2:0] {
        BAUD_9600   = 3'd0,
        BAUD_19200  = 3'd1,
        BAUD_38400  = 3'd2,
        BAUD_57600  = 3'd3,
        BAUD_115200 = 3'd4
    } baud_sel_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // Bit period expressed as (cycles per bit - 1).
    function automatic logic [15:0] baud_div(input int unsigned period_ns,
                                             input int unsigned clk_ns);
        int unsigned div;
        div = period_ns / clk_ns - 1;
        return div[15:0];
    endfunction

endpackage

// File: rtl/uart_baud_lut.sv
// Baud select to bit-period divisor; shared by the UART transmit and receive paths.
module uart_baud_lut
    import uart_pkg::*;
#(
    parameter int unsigned SYS_CLK_PERIOD = DEF_SYS_CLK_PERIOD
) (
    input  logic [2:0]  baud_set_i,
    output logic [15:0] dr_o
);

    localparam logic [15:0] DR_9600   = baud_div(BAUD_NS_9600,   SYS_CLK_PERIOD);
    localparam logic [15:0] DR_19200  = baud_div(BAUD_NS_19200,  SYS_CLK_PERIOD);
    localparam logic [15:0] DR_38400  = baud_div(BAUD_NS_38400,  SYS_CLK_PERIOD);
    localparam logic [15:0] DR_57600  = baud_div(BAUD_NS_57600,  SYS_CLK_PERIOD);
    localparam logic [15:0] DR_115200 = baud_div(BAUD_NS_115200, SYS_CLK_PERIOD);

    always_comb begin
        // NOTE: default assigned first so no path through the case can infer a latch.
        dr_o = DR_9600;
        case (baud_sel_t'(baud_set_i))
            BAUD_19200:  dr_o = DR_19200;
            BAUD_38400:  dr_o = DR_38400;
            BAUD_57600:  dr_o = DR_57600;
            BAUD_115200: dr_o = DR_115200;
            default:     dr_o = DR_9600;
        endcase
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: synchronises rx, validates the start bit at mid-bit,
// shifts in 8 data bits LSB-first and checks the stop bit.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned SYS_CLK_PERIOD = DEF_SYS_CLK_PERIOD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [2:0] baud_set,
    output logic [7:0] data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       uart_state
);

    logic        rx_meta_q, rx_s_q, rx_d_q;
    logic        start_edge;
    logic [15:0] dr_lut;
    rx_state_t   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] dr_q, dr_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    uart_baud_lut #(.SYS_CLK_PERIOD(SYS_CLK_PERIOD)) u_baud_lut (
        .baud_set_i (baud_set),
        .dr_o       (dr_lut)
    );

    // Falling edge on the synchronised line; a line held low never re-triggers.
    assign start_edge = rx_d_q & ~rx_s_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        dr_d      = dr_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = START;
                    cnt_d   = '0;
                    dr_d    = dr_lut;
                end
            end
            START: begin
                if (cnt_q == (dr_q >> 1)) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == dr_q) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == dr_q) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s_q) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            dr_q      <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_d_q    <= rx_s_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dr_q      <= dr_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign data       = data_q;
    assign rx_done    = done_q;
    assign frame_err  = err_q;
    assign uart_state = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: one instance at the real 50 MHz divisors and
// one with a scaled clock period so slow baud rates stay short.
module tb_uart_rx_byte;

    localparam int unsigned FAST_CLK_NS = 800;
    localparam int          NONE        = -10;

    typedef struct {
        bit          is_err;
        logic [7:0]  byte_v;
        int unsigned cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [2:0] baud_set = 3'd4;
    logic [7:0] data_a, data_b;
    logic       done_a, done_b, err_a, err_b, st_a, st_b;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [7:0]  last_good [2];
    int unsigned cyc = 0;
    int unsigned done_cyc_a = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    uart_rx_byte u_dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .baud_set(baud_set),
        .data(data_a), .rx_done(done_a), .frame_err(err_a), .uart_state(st_a)
    );

    uart_rx_byte #(.SYS_CLK_PERIOD(FAST_CLK_NS)) u_dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .baud_set(baud_set),
        .data(data_b), .rx_done(done_b), .frame_err(err_b), .uart_state(st_b)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    // Cycles per bit minus one, straight from bit period / clock period.
    function automatic int unsigned dr_of(input int code, input int unsigned clk_ns);
        int unsigned ns;
        case (code)
            1:       ns = 52083;
            2:       ns = 26041;
            3:       ns = 17361;
            4:       ns = 8680;
            default: ns = 104167;
        endcase
        return ns / clk_ns - 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic observe(input int which, input logic done, input logic err,
                           input logic st, input logic [7:0] d);
        exp_t e;
        bit   have;
        check("no_dual_strobe", {31'b0, done & err}, 32'd0);
        check("state_low_on_strobe", {31'b0, st}, 32'd0);
        have = (which == 0) ? (q_a.size() != 0) : (q_b.size() != 0);
        if (!have) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_strobe dut%0d: done=%0b err=%0b data=%02h, expected no strobe",
                     which, done, err, d);
            return;
        end
        e = (which == 0) ? q_a.pop_front() : q_b.pop_front();
        check("strobe_kind_err", {31'b0, err}, {31'b0, e.is_err});
        check("strobe_cycle", cyc, e.cyc);
        if (e.is_err) begin
            check("data_hold_on_err", {24'b0, d}, {24'b0, last_good[which]});
        end else begin
            check("data", {24'b0, d}, {24'b0, e.byte_v});
            last_good[which] = e.byte_v;
            if (which == 0) done_cyc_a = cyc;
        end
    endtask

    always @(negedge clk) begin
        if (done_a || err_a) observe(0, done_a, err_a, st_a, data_a);
        if (done_b || err_b) observe(1, done_b, err_b, st_b, data_b);
    end

    task automatic set_rx(input int which, input logic v);
        if (which == 0) rx_a = v;
        else            rx_b = v;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_data_a"},  {24'b0, data_a}, 32'd0);
        check({tag, "_data_b"},  {24'b0, data_b}, 32'd0);
        check({tag, "_done_b"},  {31'b0, done_b}, 32'd0);
        check({tag, "_err_b"},   {31'b0, err_b},  32'd0);
        check({tag, "_state_b"}, {31'b0, st_b},   32'd0);
        check({tag, "_state_a"}, {31'b0, st_a},   32'd0);
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
    endtask

    // Bit-accurate 8N1 transmitter; the expected strobe is queued at the falling edge.
    task automatic send_frame(input int which, input logic [7:0] b, input int unsigned dr,
                              input bit stop_bit, input int rst_bit, input int toggle_bit,
                              output int unsigned fall_cyc);
        logic [9:0] bits;
        exp_t       e;
        bits = {stop_bit, b, 1'b0};
        @(negedge clk);
        fall_cyc = cyc;
        if (rst_bit == NONE) begin
            e.is_err = ~stop_bit;
            e.byte_v = b;
            e.cyc    = cyc + 4 + dr / 2 + 9 * (dr + 1);
            if (which == 0) q_a.push_back(e);
            else            q_b.push_back(e);
        end
        for (int i = 0; i < 10; i++) begin
            set_rx(which, bits[i]);
            if (i == toggle_bit + 1) baud_set = 3'd0;
            if (i == rst_bit + 1) begin
                repeat ((dr + 1) / 2) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                reset_checks("midframe_rst");
                rst = 1'b0;
                repeat (dr + 1 - (dr + 1) / 2 - 1) @(negedge clk);
            end else begin
                repeat (dr + 1) @(negedge clk);
            end
        end
    endtask

    task automatic idle_b(input int unsigned n);
        rx_b = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned k;
        k = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("drain_pending", q_a.size() + q_b.size(), 32'd0);
    endtask

    initial begin
        int unsigned fall, dr, gap;
        int          codes [6] = '{0, 1, 2, 3, 4, 7};
        logic [7:0]  rb;
        bit          sb;

        repeat (3) @(negedge clk);
        reset_checks("init_rst");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Real-rate instance: 0x55 then 0xA3 at 115200.
        baud_set = 3'd4;
        dr = dr_of(4, 20);
        send_frame(0, 8'h55, dr, 1'b1, NONE, NONE, fall);
        drain(100);
        check("latency_115200", done_cyc_a - fall - 1, 32'd4125);
        send_frame(0, 8'hA3, dr, 1'b1, NONE, NONE, fall);
        drain(100);

        // All-zero and all-one bytes at every rate, code 7 behaving as 9600.
        foreach (codes[c]) begin
            baud_set = codes[c][2:0];
            dr = dr_of(codes[c], FAST_CLK_NS);
            send_frame(1, 8'h00, dr, 1'b1, NONE, NONE, fall);
            send_frame(1, 8'hFF, dr, 1'b1, NONE, NONE, fall);
            idle_b(3);
        end
        drain(100);

        // Stop bit low, then a 20-bit break, then a good frame.
        baud_set = 3'd0;
        dr = dr_of(0, FAST_CLK_NS);
        send_frame(1, 8'h3C, dr, 1'b0, NONE, NONE, fall);
        repeat (20 * (dr + 1)) @(negedge clk);
        check("break_stays_idle", {31'b0, st_b}, 32'd0);
        idle_b(2 * (dr + 1));
        send_frame(1, 8'h81, dr, 1'b1, NONE, NONE, fall);
        drain(100);

        // Low glitch shorter than half a bit.
        @(negedge clk);
        rx_b = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_start_seen", {31'b0, st_b}, 32'd1);
        repeat (dr / 3 - 4) @(negedge clk);
        rx_b = 1'b1;
        repeat (dr) @(negedge clk);
        check("glitch_back_idle", {31'b0, st_b}, 32'd0);
        send_frame(1, 8'h5A, dr, 1'b1, NONE, NONE, fall);
        drain(100);

        // Reset during data bit 4; the upper nibble is all ones so the rest of the
        // frame holds no falling edge.
        send_frame(1, 8'hF6, dr, 1'b1, 4, NONE, fall);
        idle_b(2 * (dr + 1));
        send_frame(1, 8'hC7, dr, 1'b1, NONE, NONE, fall);
        drain(100);

        // Baud change mid-frame applies only to the next frame.
        baud_set = 3'd4;
        send_frame(1, 8'h96, dr_of(4, FAST_CLK_NS), 1'b1, NONE, 3, fall);
        send_frame(1, 8'h69, dr_of(0, FAST_CLK_NS), 1'b1, NONE, NONE, fall);
        drain(100);

        // Random bytes, rates, stop bits and gaps.
        for (int i = 0; i < 12; i++) begin
            int code;
            code = $urandom_range(2, 4);
            baud_set = code[2:0];
            dr = dr_of(code, FAST_CLK_NS);
            rb = 8'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            send_frame(1, rb, dr, sb, NONE, NONE, fall);
            gap = sb ? $urandom_range(0, dr) : $urandom_range(2, dr + 2);
            idle_b(gap);
        end
        drain(100);
        idle_b(50);

        check("queue_a_empty", q_a.size(), 32'd0);
        check("queue_b_empty", q_b.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
